irq_sched: RTL and testbench

- Interrupt scheduler for the RISC-V CPU.
- Latches rising-edge requests from N_IRQ external sources into pending bits and arbitrates them by fixed priority (index 0 highest).
- Presents one trap request with its vector address to the CPU control path, which accepts it at an instruction boundary.
- Tracks in-service levels for nested interrupts and retires the active level on mret.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_sched.sv | 97 +++++++++
 tb/tb_irq_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

    localparam int          N_IRQ      = 3;
    localparam int          ID_W       = 2;
    localparam logic [31:0] VEC_BASE   = 32'h0000_1000;
    localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

    // Handler address of a source; 32-bit arithmetic, wrap-around ignored.
    function automatic logic [31:0] vec_of(
        input logic [31:0] id,
        input logic [31:0] base   = VEC_BASE,
        input logic [31:0] stride = VEC_STRIDE
    );
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index first-one encoder: idx of the lowest set bit of vec, vld when any bit set.
// Latency: purely combinational.
// Backpressure: none.
// Ports: vec (N-bit request vector) -> idx (ID_W, 0 when none set), vld.
module irq_prio_enc #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    vec,
    output logic [ID_W-1:0] idx,
    output logic            vld
);

    always_comb begin
        idx = '0;
        vld = |vec;
        // Scan from the top down so the lowest set index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: latches rising edges into pending, presents the best candidate by fixed priority, tracks nesting.
// Latency: edge latched on the clock that samples the rise; irq_req/irq_id/irq_vec follow the registers combinationally.
// Backpressure: requests stay pending until the CPU asserts take at an instruction boundary; ie masks only irq_req.
// Ports: clk, rst (async active-high); irq_in, ie, take, mret in;
//        irq_req, irq_id, irq_vec, pending, in_service, depth out.
module irq_sched
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = irq_pkg::N_IRQ,
    parameter int          ID_W       = irq_pkg::ID_W,
    parameter logic [31:0] VEC_BASE   = irq_pkg::VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = irq_pkg::VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ie,
    input  logic             take,
    input  logic             mret,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [31:0]      irq_vec,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [ID_W:0]    depth
);

    logic [N_IRQ-1:0] irq_d;
    logic [N_IRQ-1:0] rise;
    logic [ID_W-1:0]  pend_idx;
    logic             pend_vld;
    logic [ID_W-1:0]  top_idx;
    logic             top_vld;
    logic             cand_vld;
    logic             do_take;
    logic             do_mret;
    logic [N_IRQ-1:0] take_mask;
    logic [N_IRQ-1:0] mret_mask;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] in_service_nxt;
    logic [ID_W:0]    depth_nxt;

    irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_pend_enc (
        .vec (pending),
        .idx (pend_idx),
        .vld (pend_vld)
    );

    irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_svc_enc (
        .vec (in_service),
        .idx (top_idx),
        .vld (top_vld)
    );

    assign rise = irq_in & ~irq_d;

    // An empty in_service means top is beyond every index, so any pending source qualifies.
    assign cand_vld = pend_vld & (~top_vld | (pend_idx < top_idx));
    assign irq_req  = ie & cand_vld;
    assign irq_id   = cand_vld ? pend_idx : '0;
    assign irq_vec  = vec_of(32'(irq_id), VEC_BASE, VEC_STRIDE);

    assign do_take   = take & irq_req;
    assign do_mret   = mret & top_vld;
    assign take_mask = do_take ? (N_IRQ'(1) << irq_id) : '0;
    assign mret_mask = do_mret ? (N_IRQ'(1) << top_idx) : '0;

    // Set wins over clear so a fresh edge arriving with its own take is not lost.
    assign pending_nxt    = (pending & ~take_mask) | rise;
    // mret retires the pre-edge top before take installs its bit.
    assign in_service_nxt = (in_service & ~mret_mask) | take_mask;

    always_comb begin
        depth_nxt = depth;
        if (do_take && !do_mret) begin
            depth_nxt = depth + (ID_W+1)'(1);
        end else if (!do_take && do_mret) begin
            depth_nxt = depth - (ID_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // All-ones so a line already high at reset release is not seen as an edge.
            irq_d      <= '1;
            pending    <= '0;
            in_service <= '0;
            depth      <= '0;
        end else begin
            irq_d      <= irq_in;
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            depth      <= depth_nxt;
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
module tb_irq_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  irq_in;
    logic        ie;
    logic        take;
    logic        mret;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vec;
    logic [2:0]  pending;
    logic [2:0]  in_service;
    logic [2:0]  depth;

    int n_cmp;
    int n_bad;

    irq_sched dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .ie         (ie),
        .take       (take),
        .mret       (mret),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .in_service (in_service),
        .depth      (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        irq_in = 3'b000;
        ie     = 1'b1;
        take   = 1'b0;
        mret   = 1'b0;
        #12;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_insvc", 32'(in_service), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_req", 32'(irq_req), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);
        chk("rst_vec", irq_vec, 32'h0000_1000);
        rst = 1'b0;
        tick();

        // Single request from source 1
        irq_in = 3'b010;
        tick();
        chk("s1_pending", 32'(pending), 32'h2);
        chk("s1_req", 32'(irq_req), 32'h1);
        chk("s1_id", 32'(irq_id), 32'h1);
        chk("s1_vec", irq_vec, 32'h0000_1010);

        take = 1'b1;
        tick();
        take = 1'b0;
        chk("t1_pending", 32'(pending), 32'h0);
        chk("t1_insvc", 32'(in_service), 32'h2);
        chk("t1_depth", 32'(depth), 32'h1);
        chk("t1_req", 32'(irq_req), 32'h0);

        // Lower priority source 2 waits behind level 1
        irq_in = 3'b110;
        tick();
        chk("lo_pending", 32'(pending), 32'h4);
        chk("lo_req", 32'(irq_req), 32'h0);

        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("m1_insvc", 32'(in_service), 32'h0);
        chk("m1_depth", 32'(depth), 32'h0);
        chk("m1_req", 32'(irq_req), 32'h1);
        chk("m1_id", 32'(irq_id), 32'h2);
        chk("m1_vec", irq_vec, 32'h0000_1020);

        take = 1'b1;
        tick();
        take = 1'b0;
        chk("t2_insvc", 32'(in_service), 32'h4);
        chk("t2_depth", 32'(depth), 32'h1);

        // Source 0 preempts source 2
        irq_in = 3'b111;
        tick();
        chk("pre_pending", 32'(pending), 32'h1);
        chk("pre_req", 32'(irq_req), 32'h1);
        chk("pre_id", 32'(irq_id), 32'h0);
        chk("pre_vec", irq_vec, 32'h0000_1000);

        take = 1'b1;
        tick();
        take = 1'b0;
        chk("nest_insvc", 32'(in_service), 32'h5);
        chk("nest_depth", 32'(depth), 32'h2);
        chk("nest_req", 32'(irq_req), 32'h0);

        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("unnest_insvc", 32'(in_service), 32'h4);
        chk("unnest_depth", 32'(depth), 32'h1);

        // ie masks only irq_req; simultaneous rises both latch
        irq_in = 3'b000;
        tick();
        ie = 1'b0;
        irq_in = 3'b101;
        tick();
        chk("mask_pending", 32'(pending), 32'h5);
        chk("mask_req", 32'(irq_req), 32'h0);
        ie = 1'b1;
        #1;
        chk("unmask_req", 32'(irq_req), 32'h1);
        chk("unmask_id", 32'(irq_id), 32'h0);

        take = 1'b1;
        tick();
        take = 1'b0;
        chk("t3_pending", 32'(pending), 32'h4);
        chk("t3_depth", 32'(depth), 32'h2);
        repeat (10) tick();
        chk("hold_pending", 32'(pending), 32'h4);
        chk("hold_req", 32'(irq_req), 32'h0);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pending", 32'(pending), 32'h0);
        chk("arst_insvc", 32'(in_service), 32'h0);
        chk("arst_depth", 32'(depth), 32'h0);
        chk("arst_req", 32'(irq_req), 32'h0);
        chk("arst_vec", irq_vec, 32'h0000_1000);

        // Line held high through reset release gives no request
        irq_in = 3'b010;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("held_pending", 32'(pending), 32'h0);
        chk("held_req", 32'(irq_req), 32'h0);

        // mret with nothing in service is ignored
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_empty_depth", 32'(depth), 32'h0);
        chk("mret_empty_insvc", 32'(in_service), 32'h0);

        // take and mret together
        irq_in = 3'b000;
        tick();
        irq_in = 3'b100;
        tick();
        take = 1'b1;
        tick();
        take = 1'b0;
        chk("tm_setup_insvc", 32'(in_service), 32'h4);
        irq_in = 3'b101;
        tick();
        chk("tm_cand_id", 32'(irq_id), 32'h0);
        take = 1'b1;
        mret = 1'b1;
        tick();
        take = 1'b0;
        mret = 1'b0;
        chk("tm_insvc", 32'(in_service), 32'h1);
        chk("tm_depth", 32'(depth), 32'h1);
        chk("tm_pending", 32'(pending), 32'h0);

        // Rise of a source in the same cycle as its take keeps it pending
        irq_in = 3'b100;
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("rt_pre_depth", 32'(depth), 32'h0);
        irq_in = 3'b101;
        tick();
        irq_in = 3'b100;
        tick();
        irq_in = 3'b101;
        take = 1'b1;
        tick();
        take = 1'b0;
        chk("rt_pending", 32'(pending), 32'h1);
        chk("rt_insvc", 32'(in_service), 32'h1);
        chk("rt_depth", 32'(depth), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
